// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock time-set logic: FSM states, set-button
// mode codes and the divider sizing functions.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_HR  = 3'd2,
    CLEAR   = 3'd3,
    EXIT    = 3'd4
  } state_e;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_MIN  = 2'b01;
  localparam logic [1:0] MODE_HR   = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic int unsigned set_div(input int unsigned clk_hz, input int unsigned set_hz);
    return clk_hz / set_hz;
  endfunction

  // Keep at least one bit so a degenerate divide-by-1 still elaborates.
  function automatic int unsigned div_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/set_rate_divider.sv
// Reloadable repeat-rate counter; o_tc is combinational off the count, so the
// strobe it drives lands one cycle later once registered. No backpressure.
module set_rate_divider
  import clock_pkg::*;
#(
  parameter int unsigned SLOW_DIV = 50,
  parameter int unsigned FAST_DIV = 20,
  parameter int unsigned DIV_W    = div_width(SLOW_DIV)
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_restart,
  input  logic i_run,
  input  logic i_fast,
  output logic o_tc
);

  localparam logic [DIV_W-1:0] SLOW_TC = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_TC = DIV_W'(FAST_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // ">=" rather than "==" so a slow->fast switch past the fast terminal fires at once.
  always_comb begin
    o_tc  = i_run && (cnt_q >= (i_fast ? FAST_TC : SLOW_TC));
    cnt_d = cnt_q + DIV_W'(1);
    if (i_restart || !i_run || o_tc) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer: button levels -> registered hours/minutes strobes, seconds
// hold and clear. Outputs follow the sampling edge by one cycle; no backpressure.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ  = 5_000_000,
  parameter int unsigned SLOW_SET_HZ = 2,
  parameter int unsigned FAST_SET_HZ = 5
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_fast_set,
  output logic       o_inc_hours,
  output logic       o_inc_minutes,
  output logic       o_hold,
  output logic       o_clr_seconds,
  output logic       o_setting
);

  localparam int unsigned SLOW_DIV = set_div(SYS_CLK_HZ, SLOW_SET_HZ);
  localparam int unsigned FAST_DIV = set_div(SYS_CLK_HZ, FAST_SET_HZ);
  localparam int unsigned DIV_W    = div_width(SLOW_DIV);

  state_e state_q, state_d;
  logic   inc_hr_q, inc_hr_d, inc_min_q, inc_min_d;
  logic   hold_q, hold_d, clr_q, clr_d, setting_q, setting_d;
  logic   in_set_q, in_set_d, div_run, div_restart, div_tc;

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          case (i_mode)
            MODE_MIN:  state_d = SET_MIN;
            MODE_HR:   state_d = SET_HR;
            MODE_BOTH: state_d = CLEAR;
            default:   state_d = IDLE;
          endcase
        end
        SET_MIN, SET_HR: begin
          case (i_mode)
            MODE_NONE: state_d = EXIT;
            MODE_BOTH: state_d = CLEAR;
            MODE_MIN:  state_d = SET_MIN;
            default:   state_d = SET_HR;
          endcase
        end
        CLEAR:   state_d = (i_mode == MODE_BOTH) ? CLEAR : EXIT;
        default: state_d = IDLE;
      endcase
    end

    in_set_q    = (state_q == SET_MIN) || (state_q == SET_HR);
    in_set_d    = (state_d == SET_MIN) || (state_d == SET_HR);
    div_run     = in_set_q && (state_d == state_q);
    div_restart = in_set_d && (state_d != state_q);

    // Entry (including a swap) strobes immediately; staying strobes on terminal count.
    inc_min_d = (state_d == SET_MIN) && ((state_q != SET_MIN) || div_tc);
    inc_hr_d  = (state_d == SET_HR)  && ((state_q != SET_HR)  || div_tc);
    hold_d    = (state_d != IDLE);
    setting_d = in_set_d;
    clr_d     = ((state_d == CLEAR) && (state_q != CLEAR)) || (state_d == EXIT);
  end

  set_rate_divider #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_restart (div_restart),
    .i_run     (div_run),
    .i_fast    (i_fast_set),
    .o_tc      (div_tc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      hold_q    <= 1'b0;
      clr_q     <= 1'b0;
      setting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      hold_q    <= hold_d;
      clr_q     <= clr_d;
      setting_q <= setting_d;
    end
  end

  assign o_inc_hours   = inc_hr_q;
  assign o_inc_minutes = inc_min_q;
  assign o_hold        = hold_q;
  assign o_clr_seconds = clr_q;
  assign o_setting     = setting_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic
// checked against a behavioural model of the time-set rules.
module tb_clock_set_controller;

  localparam int SLOW_P = 100 / 2;
  localparam int FAST_P = 100 / 5;
  localparam int M_IDLE = 0, M_MIN = 1, M_HR = 2, M_CLR = 3, M_EXIT = 4;

  logic       i_clk = 1'b0;
  logic       i_reset_n, i_en, i_fast_set;
  logic [1:0] i_mode;
  logic       o_inc_hours, o_inc_minutes, o_hold, o_clr_seconds, o_setting;

  int   tests = 0, fails = 0, cyc = 0;
  int   mst, age;
  logic e_hr, e_min, e_hold, e_clr, e_set;

  clock_set_controller #(
    .SYS_CLK_HZ  (100),
    .SLOW_SET_HZ (2),
    .FAST_SET_HZ (5)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_en          (i_en),
    .i_mode        (i_mode),
    .i_fast_set    (i_fast_set),
    .o_inc_hours   (o_inc_hours),
    .o_inc_minutes (o_inc_minutes),
    .o_hold        (o_hold),
    .o_clr_seconds (o_clr_seconds),
    .o_setting     (o_setting)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE; age = 0;
    e_hr = 0; e_min = 0; e_hold = 0; e_clr = 0; e_set = 0;
  endtask

  // age = cycles spent in the current set state since its last strobe.
  task automatic model_step(input logic [1:0] m, input logic f, input logic en);
    int   prev, nxt;
    logic strobe;
    if (!en) begin
      model_reset();
      return;
    end
    prev   = mst;
    strobe = 1'b0;
    if (prev == M_EXIT)     nxt = M_IDLE;
    else if (prev == M_CLR) nxt = (m == 2'd3) ? M_CLR : M_EXIT;
    else if (m == 2'd3)     nxt = M_CLR;
    else if (m == 2'd1)     nxt = M_MIN;
    else if (m == 2'd2)     nxt = M_HR;
    else                    nxt = (prev == M_IDLE) ? M_IDLE : M_EXIT;
    if (nxt == M_MIN || nxt == M_HR) begin
      if (nxt != prev) begin
        strobe = 1'b1; age = 0;
      end else if (age + 1 >= (f ? FAST_P : SLOW_P)) begin
        strobe = 1'b1; age = 0;
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
    mst    = nxt;
    e_min  = strobe && (nxt == M_MIN);
    e_hr   = strobe && (nxt == M_HR);
    e_hold = (nxt != M_IDLE);
    e_set  = (nxt == M_MIN) || (nxt == M_HR);
    e_clr  = (nxt == M_EXIT) || (nxt == M_CLR && prev != M_CLR);
  endtask

  task automatic check_outputs();
    check("inc_hours",   o_inc_hours,   e_hr);
    check("inc_minutes", o_inc_minutes, e_min);
    check("hold",        o_hold,        e_hold);
    check("clr_seconds", o_clr_seconds, e_clr);
    check("setting",     o_setting,     e_set);
    check("exclusive",   o_inc_hours & o_inc_minutes, 1'b0);
  endtask

  task automatic step(input logic [1:0] m, input logic f, input logic en);
    i_mode = m; i_fast_set = f; i_en = en;
    @(posedge i_clk);
    cyc++;
    model_step(m, f, en);
    #1;
    check_outputs();
  endtask

  initial begin
    int q[$];
    int exp_s[3];
    int t0, nclr, ninc, len;
    logic [1:0] m;
    logic f, en;

    i_reset_n = 1'b0; i_en = 1'b1; i_mode = 2'b00; i_fast_set = 1'b0;
    model_reset();
    #12;
    check_outputs();
    #1 i_reset_n = 1'b1;

    // Slow minutes set: strobes 1, 51, 101 cycles after the sampling edge.
    t0 = cyc;
    for (int i = 0; i < 120; i++) begin
      step(2'b01, 1'b0, 1'b1);
      check("hold_in_set", o_hold, 1'b1);
      if (o_inc_minutes) q.push_back(cyc - t0);
    end
    check_int("slow_strobe_count", q.size(), 3);
    exp_s = '{1, 51, 101};
    for (int k = 0; k < 3; k++)
      check_int("slow_strobe_cycle", (k < q.size()) ? q[k] : -1, exp_s[k]);
    step(2'b00, 1'b0, 1'b1);
    check("release_clr", o_clr_seconds, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    check("release_hold", o_hold, 1'b0);

    // Fast hours: strobe spacing of 20.
    q.delete();
    t0 = cyc;
    for (int i = 0; i < 45; i++) begin
      step(2'b10, 1'b1, 1'b1);
      if (o_inc_hours) q.push_back(cyc - t0);
    end
    check_int("fast_strobe_count", q.size(), 3);
    if (q.size() == 3) check_int("fast_period", q[2] - q[1], FAST_P);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);

    // Slow hours, switch to fast with the divider at 30.
    for (int i = 0; i < 31; i++) step(2'b10, 1'b0, 1'b1);
    step(2'b10, 1'b1, 1'b1);
    check("switch_strobe", o_inc_hours, 1'b1);
    ninc = 0;
    for (int i = 0; i < 19; i++) begin
      step(2'b10, 1'b1, 1'b1);
      ninc += int'(o_inc_hours);
    end
    check_int("switch_gap_quiet", ninc, 0);
    step(2'b10, 1'b1, 1'b1);
    check("switch_next_strobe", o_inc_hours, 1'b1);

    // Direct swap hours -> minutes -> hours.
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b1);
    check("swap_inc_hours", o_inc_hours, 1'b1);
    check("swap_no_clr", o_clr_seconds, 1'b0);
    check("swap_hold", o_hold, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);

    // Both pressed for 100 cycles: two clears, no increments.
    nclr = 0; ninc = 0;
    for (int i = 0; i < 103; i++) begin
      step((i < 100) ? 2'b11 : 2'b00, 1'b0, 1'b1);
      nclr += int'(o_clr_seconds);
      ninc += int'(o_inc_hours) + int'(o_inc_minutes);
    end
    check_int("both_clr_pulses", nclr, 2);
    check_int("both_inc_pulses", ninc, 0);

    // Enable dropped mid-set.
    for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0);
    check("en_low_hold", o_hold, 1'b0);
    check("en_low_clr", o_clr_seconds, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);

    // Asynchronous reset mid-set, then restart from reset.
    for (int i = 0; i < 7; i++) step(2'b01, 1'b0, 1'b1);
    #3 i_reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #2 i_reset_n = 1'b1;
    step(2'b01, 1'b0, 1'b1);
    check("post_reset_strobe", o_inc_minutes, 1'b1);

    // Random button traffic.
    f = 1'b0;
    for (int s = 0; s < 40; s++) begin
      m   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 70));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 24) == 0) f = ~f;
        en = ($urandom_range(0, 99) != 0);
        step(m, f, en);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
